pwm_capture: RTL

Measures an incoming PWM waveform and reports high time, period and duty cycle in integer percent. It is the receive-side counterpart of the team's PWM generators and is used in closed-loop tests and for reading external PWM sources. The input is synchronised internally. A stuck-high or stuck-low line is detected by a programmable timeout.

---
 rtl/pwm_capture.sv | 188 ++++++++++++++++++
 1 files changed

// File: rtl/pwm_capture.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pwm_capture: measures high time, period and duty (%) of an async PWM line |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module pwm_capture #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 50000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [CNT_W-1:0] high_cnt,
  output logic [CNT_W-1:0] period_cnt,
  output logic [6:0]       duty_pct,
  output logic             valid,
  output logic             overrun,
  output logic             stuck_hi,
  output logic             stuck_lo
);

  localparam int               c_DIV_W   = CNT_W + 7;
  localparam logic [CNT_W-1:0] c_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_RISE = 2'd0,
    HIGH      = 2'd1,
    LOW       = 2'd2
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic                   w_s, w_rise, w_fall, w_edge;
  logic [CNT_W-1:0]       r_per, r_high, r_age;
  logic                   w_timeout, w_period_done, w_latch_high;
  logic                   w_launch, w_overrun, w_last, w_ge;
  logic                   r_busy;
  logic [2:0]             r_step;
  logic [c_DIV_W-1:0]     r_rem, r_dsh, w_rem_nxt, w_dividend;
  logic [5:0]             r_quo;
  logic [CNT_W-1:0]       r_op_high, r_op_per;

  assign w_s    = r_sync[SYNC_STAGES-1];
  assign w_rise = w_s & ~r_prev;
  assign w_fall = ~w_s & r_prev;
  assign w_edge = w_rise | w_fall;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], pwm_in};
      r_prev <= w_s;
    end
  end

  // Edge age saturates at TIMEOUT so the stuck event fires exactly once per quiet spell
  assign w_timeout = !w_edge && (r_age == (c_TIMEOUT - c_ONE));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_age <= '0;
    end else if (w_edge) begin
      r_age <= '0;
    end else if (r_age != c_TIMEOUT) begin
      r_age <= r_age + c_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= WAIT_RISE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_period_done = 1'b0;
    w_latch_high  = 1'b0;
    if (w_timeout) begin
      w_state_nxt = WAIT_RISE;
    end else begin
      case (r_state)
        WAIT_RISE: if (w_rise) w_state_nxt = HIGH;
        HIGH: if (w_fall) begin
          w_state_nxt  = LOW;
          w_latch_high = 1'b1;
        end
        LOW: if (w_rise) begin
          w_state_nxt   = HIGH;
          w_period_done = 1'b1;
        end
        default: w_state_nxt = WAIT_RISE;
      endcase
    end
  end

  // One counter serves both measurements: high time is sampled from it at the fall
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_per  <= '0;
      r_high <= '0;
    end else begin
      if (w_rise) begin
        r_per <= c_ONE;
      end else if (r_state != WAIT_RISE && r_per != '1) begin
        r_per <= r_per + c_ONE;
      end
      if (w_latch_high) r_high <= r_per;
    end
  end

  assign w_launch   = w_period_done && !r_busy;
  assign w_overrun  = w_period_done && r_busy;
  assign w_last     = r_busy && (r_step == 3'd6);
  assign w_dividend = c_DIV_W'(r_high) * c_DIV_W'(100);
  assign w_ge       = (r_rem >= r_dsh);
  assign w_rem_nxt  = w_ge ? (r_rem - r_dsh) : r_rem;

  // Quotient never exceeds 127, so the divisor starts pre-shifted by 6 and 7 steps suffice
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy    <= 1'b0;
      r_step    <= 3'd0;
      r_rem     <= '0;
      r_dsh     <= '0;
      r_quo     <= '0;
      r_op_high <= '0;
      r_op_per  <= '0;
    end else if (w_timeout) begin
      r_busy <= 1'b0;
    end else if (w_launch) begin
      r_busy    <= 1'b1;
      r_step    <= 3'd0;
      r_rem     <= w_dividend;
      r_dsh     <= {1'b0, r_per, 6'b0};
      r_quo     <= '0;
      r_op_high <= r_high;
      r_op_per  <= r_per;
    end else if (r_busy) begin
      r_rem  <= w_rem_nxt;
      r_dsh  <= r_dsh >> 1;
      r_quo  <= {r_quo[4:0], w_ge};
      r_step <= r_step + 3'd1;
      if (w_last) r_busy <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      duty_pct   <= 7'd0;
      valid      <= 1'b0;
      overrun    <= 1'b0;
      stuck_hi   <= 1'b0;
      stuck_lo   <= 1'b0;
    end else begin
      valid   <= 1'b0;
      overrun <= w_overrun;
      if (w_timeout) begin
        valid      <= 1'b1;
        high_cnt   <= '0;
        period_cnt <= '0;
        duty_pct   <= w_s ? 7'd100 : 7'd0;
        stuck_hi   <= w_s;
        stuck_lo   <= ~w_s;
      end else begin
        if (w_last) begin
          valid      <= 1'b1;
          high_cnt   <= r_op_high;
          period_cnt <= r_op_per;
          duty_pct   <= {r_quo, w_ge};
        end
        if (w_edge) begin
          stuck_hi <= 1'b0;
          stuck_lo <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire
